wb_merge_stage: RTL

- Writeback stage directly upstream of the 8 x 16-bit register file. It drives that file's single write port (write enable, 3-bit dest, 16-bit data).
- Merges results from two producers: the ALU (single-cycle) and the data-memory load path (variable latency).
- Results go through an in-order FIFO so that same-cycle collisions never drop a write.
- Drives backpressure to both producers.

---
 rtl/wb_merge_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_merge_stage.sv
// wb_merge_stage: writeback merge stage feeding the single write port of the
// register file. ALU and load results are pushed into a small in-order FIFO
// so that same-cycle collisions never lose a write. The head entry drains
// through a registered output, one entry per cycle.
//
// Optional feature: define WB_MERGE_FWD_EN to add two combinational
// forwarding lookup ports that search the FIFO and the output register.
//
// Handshake: a source transfers on a rising edge where valid && ready.
// Ready is computed from registered occupancy (plus mem_valid for the ALU
// side, because the load path has priority) and never from the source's own
// valid. A pop in the same cycle gives no credit, so the FIFO cannot overflow.
module wb_merge_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4     // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,

    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_data,

    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     pending
`ifdef WB_MERGE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_addr_1,
    output logic                     fwd_hit_1,
    output logic [DATA_W-1:0]        fwd_data_1,
    input  logic [ADDR_W-1:0]        fwd_addr_2,
    output logic                     fwd_hit_2,
    output logic [DATA_W-1:0]        fwd_data_2
`endif
);

    // Pointer width and occupancy width (occupancy must be able to hold DEPTH).
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage. Contents are don't-care until written, so no reset.
    logic [ADDR_W-1:0] r_dest_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];

    // FIFO control state.
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    // Registered output toward the register file.
    logic              r_out_en;
    logic [ADDR_W-1:0] r_out_dest;
    logic [DATA_W-1:0] r_out_data;

    // Handshake and datapath control.
    logic              w_mem_ready;
    logic              w_alu_ready;
    logic [CW:0]       w_alu_need;
    logic              w_mem_fire;
    logic              w_alu_fire;
    logic              w_push_mem;
    logic              w_push_alu;
    logic              w_pop;
    logic [PW-1:0]     w_alu_wptr;

    // Load path only needs one free slot. The ALU needs a slot beyond the one
    // a simultaneous load would take, so mem_valid is added to its occupancy.
    assign w_mem_ready = (r_count <= CW'(DEPTH - 1));
    assign w_alu_need  = {1'b0, r_count} + {{CW{1'b0}}, mem_valid};
    assign w_alu_ready = (w_alu_need <= {1'b0, CW'(DEPTH - 1)});

    assign w_mem_fire  = mem_valid & w_mem_ready;
    assign w_alu_fire  = alu_valid & w_alu_ready;

    // Writes to r0 complete their handshake but are dropped here: r0 is
    // hard-wired to zero, so queuing them would only waste a slot.
    assign w_push_mem  = w_mem_fire & (mem_dest != '0);
    assign w_push_alu  = w_alu_fire & (alu_dest != '0);

    // One pop per cycle whenever anything is queued.
    assign w_pop       = (r_count != '0);

    // When both push on the same edge the load goes first, so the ALU entry
    // lands one slot behind it.
    assign w_alu_wptr  = r_wptr + PW'(w_push_mem);

    // Store incoming entries at the tail (load entry first on a collision).
    always_ff @(posedge clk) begin
        if (w_push_mem) begin
            r_dest_mem[r_wptr] <= mem_dest;
            r_data_mem[r_wptr] <= mem_data;
        end
        if (w_push_alu) begin
            r_dest_mem[w_alu_wptr] <= alu_dest;
            r_data_mem[w_alu_wptr] <= alu_data;
        end
    end

    // Advance pointers (natural wrap, DEPTH is a power of 2) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push_mem) + PW'(w_push_alu);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(w_push_mem) + CW'(w_push_alu) - CW'(w_pop);
        end
    end

    // Move the head entry into the output register; hold dest/data when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en   <= 1'b0;
            r_out_dest <= '0;
            r_out_data <= '0;
        end else if (w_pop) begin
            r_out_en   <= 1'b1;
            r_out_dest <= r_dest_mem[r_rptr];
            r_out_data <= r_data_mem[r_rptr];
        end else begin
            r_out_en   <= 1'b0;
        end
    end

    assign alu_ready      = w_alu_ready;
    assign mem_ready      = w_mem_ready;
    assign reg_write_en   = r_out_en;
    assign reg_write_dest = r_out_dest;
    assign reg_write_data = r_out_data;
    assign count          = r_count;
    assign pending        = (r_count != '0) || r_out_en;

`ifdef WB_MERGE_FWD_EN
    // Youngest-match lookup: the output register is the oldest candidate,
    // then FIFO entries head to tail, so a later match overrides an earlier
    // one. Incoming same-cycle transfers are deliberately not searched.
    // Returns {hit, data}; data is zero on a miss.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PW-1:0]     idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (addr != '0) begin
            if (r_out_en && (r_out_dest == addr)) begin
                hit  = 1'b1;
                data = r_out_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_rptr + PW'(i);
                if ((CW'(i) < r_count) && (r_dest_mem[idx] == addr)) begin
                    hit  = 1'b1;
                    data = r_data_mem[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    // Forwarding lookups for both read ports.
    always_comb begin
        {fwd_hit_1, fwd_data_1} = fwd_lookup(fwd_addr_1);
        {fwd_hit_2, fwd_data_2} = fwd_lookup(fwd_addr_2);
    end
`endif

endmodule
